wb_arbiter_2to1: RTL and testbench

- Two-master to one-slave pipelined Wishbone arbiter.
- Shares a single sp_mem_wb instance between the instruction-fetch port (m0) and the data port (m1) of yarc_platform.
- Grants are held for a whole bus cycle (CYC high) and rotate round-robin between cycles.
- Tracks outstanding pipelined requests so responses always route to the master that issued them.

---
 rtl/wb_arbiter_2to1.sv | 186 ++++++++++++++++++
 tb/tb_wb_arbiter_2to1.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// A grant is held for a whole bus cycle (CYC high) and rotates round-robin
// at cycle boundaries. Accepted-but-unanswered requests are counted so the
// strobe can be throttled. Responses still owed for an aborted cycle are
// counted separately and swallowed so they never reach the next owner.
module wb_arbiter_2to1 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  // master 0 (instruction fetch)
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_wdata_i,
  output logic [DW-1:0]   m0_rdata_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  output logic            m0_stall_o,
  // master 1 (data)
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_wdata_i,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic            m1_stall_o,
  // shared slave
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [DW-1:0]   s_wdata_o,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  input  logic            s_stall_i
);

  localparam int CW  = $clog2(MAX_OUTST + 1);
  // Aborted responses can pile up across back-to-back aborts; the drain
  // counter saturates at twice the window.
  localparam int DRW = $clog2(2 * MAX_OUTST + 1);
  localparam logic [DRW:0] DRAIN_MAX = (DRW + 1)'(2 * MAX_OUTST);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [DRW-1:0]   drain_q, drain_d;

  logic             full;
  logic             resp_raw;
  logic             stale;
  logic             accept;
  logic             resp_cnt;
  logic [CW-1:0]    outst_upd;
  logic [DRW-1:0]   drain_dec;
  logic [DRW:0]     drain_sum;
  logic [DRW-1:0]   drain_rel;

  assign full     = (outst_q == CW'(MAX_OUTST));
  assign resp_raw = s_ack_i | s_err_i | s_rty_i;
  // While drain is non-zero, slave responses belong to an aborted cycle.
  assign stale    = (drain_q != '0);

  // Route the granted master to the slave and slave responses back to it.
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_sel_o    = '0;
    s_wdata_o  = '0;
    m0_rdata_o = s_rdata_i;
    m1_rdata_o = s_rdata_i;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_rty_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_rty_o   = 1'b0;
    m1_stall_o = 1'b1;
    case (state_q)
      G0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_cyc_i & m0_stb_i & ~full;
        s_we_o     = m0_we_i;
        s_addr_o   = m0_addr_i;
        s_sel_o    = m0_sel_i;
        s_wdata_o  = m0_wdata_i;
        m0_stall_o = s_stall_i | full;
        m0_ack_o   = s_ack_i & ~stale;
        m0_err_o   = s_err_i & ~stale;
        m0_rty_o   = s_rty_i & ~stale;
      end
      G1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_cyc_i & m1_stb_i & ~full;
        s_we_o     = m1_we_i;
        s_addr_o   = m1_addr_i;
        s_sel_o    = m1_sel_i;
        s_wdata_o  = m1_wdata_i;
        m1_stall_o = s_stall_i | full;
        m1_ack_o   = s_ack_i & ~stale;
        m1_err_o   = s_err_i & ~stale;
        m1_rty_o   = s_rty_i & ~stale;
      end
      default: ;
    endcase
  end

  // Arbitration, outstanding-request accounting and abort draining.
  always_comb begin
    accept   = s_cyc_o & s_stb_o & ~s_stall_i;
    // A response with nothing outstanding is ignored.
    resp_cnt = resp_raw & ~stale & (outst_q != '0);
    case ({accept, resp_cnt})
      2'b10:   outst_upd = outst_q + CW'(1);
      2'b01:   outst_upd = outst_q - CW'(1);
      default: outst_upd = outst_q;
    endcase
    drain_dec = (stale & resp_raw) ? drain_q - DRW'(1) : drain_q;
    drain_sum = {1'b0, drain_dec} + (DRW + 1)'(outst_upd);
    drain_rel = (drain_sum > DRAIN_MAX) ? DRAIN_MAX[DRW-1:0] : drain_sum[DRW-1:0];

    state_d = state_q;
    last_d  = last_q;
    outst_d = outst_upd;
    drain_d = drain_dec;
    case (state_q)
      IDLE: begin
        outst_d = '0;
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? G0 : G1;
        else if (m0_cyc_i)        state_d = G0;
        else if (m1_cyc_i)        state_d = G1;
      end
      G0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          outst_d = '0;
          drain_d = drain_rel;
          state_d = m1_cyc_i ? G1 : IDLE;
        end
      end
      G1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          outst_d = '0;
          drain_d = drain_rel;
          state_d = m0_cyc_i ? G0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin history and counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      outst_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      drain_q <= drain_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1: a vector table applied during an m0
// grant, plus hand-written multi-cycle sequences.
module tb_wb_arbiter_2to1;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0]   m0_addr_i;
  logic [DW/8-1:0] m0_sel_i;
  logic [DW-1:0]   m0_wdata_i, m0_rdata_o;
  logic            m0_ack_o, m0_err_o, m0_rty_o, m0_stall_o;
  logic            m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0]   m1_addr_i;
  logic [DW/8-1:0] m1_sel_i;
  logic [DW-1:0]   m1_wdata_i, m1_rdata_o;
  logic            m1_ack_o, m1_err_o, m1_rty_o, m1_stall_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW/8-1:0] s_sel_o;
  logic [DW-1:0]   s_wdata_o, s_rdata_i;
  logic            s_ack_i, s_err_i, s_rty_i, s_stall_i;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.AW(AW), .DW(DW), .MAX_OUTST(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_rty_o(m0_rty_o), .m0_stall_o(m0_stall_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_rty_o(m1_rty_o), .m1_stall_o(m1_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_sel_o(s_sel_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .s_stall_i(s_stall_i)
  );

  typedef struct {
    logic        stb, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        stall, ack, err, rty;
    logic [31:0] rdata;
    logic        e_stb, e_stall, e_ack, e_err, e_rty;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Advance to the next falling edge; inputs are driven there and outputs
  // are sampled 1 time unit later, well away from the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    step();
    reset_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_stall_i = 0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    reset_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_sel_i = 4'hF; m0_wdata_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_sel_i = 4'hF; m1_wdata_i = '0;
    s_rdata_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_stall_i = 0;

    //          stb we addr      sel   wdata         stl ack err rty rdata        e_stb e_stl e_ack e_err e_rty
    vt[0] = '{1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 32'h104, 4'h3, 32'h00001234, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h200, 4'h1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 32'h300, 4'hC, 32'h0000A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 32'h304, 4'h2, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h77,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 32'h308, 4'h8, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h99,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // ---- reset state ----
    do_reset();
    settle();
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_m0_stall", m0_stall_o, 1);
    chk("rst_m1_stall", m1_stall_o, 1);
    chk("rst_m0_ack", m0_ack_o, 0);
    chk("rst_m1_ack", m1_ack_o, 0);
    chk("rst_outst", dut.outst_q, 0);

    // ---- single m0 read burst ----
    step(); m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h0; settle();
    chk("t1_stb_idle", s_stb_o, 0);
    step(); settle();
    chk("t1_stb_n1", s_stb_o, 1);
    chk("t1_addr0", s_addr_o, 32'h0);
    chk("t1_m0_stall", m0_stall_o, 0);
    step(); m0_addr_i = 32'h4; s_ack_i = 1; s_rdata_i = 32'hA0; settle();
    chk("t1_ack0", m0_ack_o, 1);
    chk("t1_rdata0", m0_rdata_o, 32'hA0);
    chk("t1_m1_ack0", m1_ack_o, 0);
    chk("t1_addr4", s_addr_o, 32'h4);
    step(); m0_addr_i = 32'h8; s_rdata_i = 32'hA4; settle();
    chk("t1_ack1", m0_ack_o, 1);
    chk("t1_rdata1", m0_rdata_o, 32'hA4);
    step(); m0_stb_i = 0; s_rdata_i = 32'hA8; settle();
    chk("t1_ack2", m0_ack_o, 1);
    chk("t1_rdata2", m0_rdata_o, 32'hA8);
    chk("t1_m1_ack2", m1_ack_o, 0);
    step(); s_ack_i = 0; settle();
    chk("t1_outst0", dut.outst_q, 0);
    step(); m0_cyc_i = 0; settle();
    chk("t1_release_cyc", s_cyc_o, 0);
    step(); settle();
    chk("t1_idle_stall", m0_stall_o, 1);

    // ---- vector table during an m0 grant (m1 waiting) ----
    step(); m0_cyc_i = 1; m0_stb_i = 0; settle();
    for (int i = 0; i < 6; i++) begin
      step();
      m1_cyc_i = 1;
      m0_stb_i = vt[i].stb; m0_we_i = vt[i].we; m0_addr_i = vt[i].addr;
      m0_sel_i = vt[i].sel; m0_wdata_i = vt[i].wdata;
      s_stall_i = vt[i].stall; s_ack_i = vt[i].ack; s_err_i = vt[i].err;
      s_rty_i = vt[i].rty; s_rdata_i = vt[i].rdata;
      settle();
      chk($sformatf("v%0d_s_stb", i), s_stb_o, vt[i].e_stb);
      chk($sformatf("v%0d_s_we", i), s_we_o, vt[i].we);
      chk($sformatf("v%0d_s_addr", i), s_addr_o, vt[i].addr);
      chk($sformatf("v%0d_s_sel", i), s_sel_o, vt[i].sel);
      chk($sformatf("v%0d_s_wdata", i), s_wdata_o, vt[i].wdata);
      chk($sformatf("v%0d_m0_stall", i), m0_stall_o, vt[i].e_stall);
      chk($sformatf("v%0d_m0_ack", i), m0_ack_o, vt[i].e_ack);
      chk($sformatf("v%0d_m0_err", i), m0_err_o, vt[i].e_err);
      chk($sformatf("v%0d_m0_rty", i), m0_rty_o, vt[i].e_rty);
      chk($sformatf("v%0d_m0_rdata", i), m0_rdata_o, vt[i].rdata);
      chk($sformatf("v%0d_m1_ack", i), m1_ack_o, 0);
      chk($sformatf("v%0d_m1_err", i), m1_err_o, 0);
      chk($sformatf("v%0d_m1_stall", i), m1_stall_o, 1);
    end
    step();
    m0_cyc_i = 0; m1_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF;
    s_stall_i = 0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;

    // ---- simultaneous requests and round-robin ----
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1; settle();
    chk("t2_idle_cyc", s_cyc_o, 0);
    step(); settle();
    chk("t2_g0_m0_stall", m0_stall_o, 0);
    chk("t2_g0_m1_stall", m1_stall_o, 1);
    chk("t2_g0_cyc", s_cyc_o, 1);
    step(); m0_cyc_i = 0; settle();
    chk("t2_rel_cyc", s_cyc_o, 0);
    step(); settle();
    chk("t2_g1_m1_stall", m1_stall_o, 0);
    chk("t2_g1_m0_stall", m0_stall_o, 1);
    chk("t2_g1_cyc", s_cyc_o, 1);
    step(); m1_cyc_i = 0;
    step(); m0_cyc_i = 1; m1_cyc_i = 1;
    step(); settle();
    chk("t2_rr_g0_m0", m0_stall_o, 0);
    chk("t2_rr_g0_m1", m1_stall_o, 1);
    step(); m0_cyc_i = 0; m1_cyc_i = 0;
    step(); m0_cyc_i = 1; m1_cyc_i = 1;
    step(); settle();
    chk("t2_rr_g1_m1", m1_stall_o, 0);
    chk("t2_rr_g1_m0", m0_stall_o, 1);
    step(); m0_cyc_i = 0; m1_cyc_i = 0;

    // ---- outstanding limit with m1 streaming writes ----
    step(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h40;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(); settle();
      chk($sformatf("t3_stb_%0d", i), s_stb_o, (i < 4) ? 1 : 0);
      chk($sformatf("t3_stall_%0d", i), m1_stall_o, (i < 4) ? 0 : 1);
      if (s_cyc_o && s_stb_o && !s_stall_i) acc++;
    end
    chk("t3_accepts", acc, 4);
    chk("t3_we", s_we_o, 1);
    step(); s_ack_i = 1; settle();
    chk("t3_full_stb", s_stb_o, 0);
    chk("t3_full_stall", m1_stall_o, 1);
    chk("t3_full_ack", m1_ack_o, 1);
    step(); s_ack_i = 0; settle();
    chk("t3_after_ack_stb", s_stb_o, 1);
    chk("t3_after_ack_stall", m1_stall_o, 0);
    step(); m1_stb_i = 0; s_ack_i = 1;
    step(); step(); step();
    step(); s_ack_i = 0; settle();
    chk("t3_drained", dut.outst_q, 0);
    step(); m1_cyc_i = 0; m1_we_i = 0;

    // ---- slave stall during an m0 burst ----
    step(); m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h80;
    step(); settle();
    chk("t4_stb", s_stb_o, 1);
    chk("t4_stall0", m0_stall_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(); s_stall_i = 1; settle();
      chk($sformatf("t4_stalled_%0d", i), m0_stall_o, 1);
      chk($sformatf("t4_outst_%0d", i), dut.outst_q, 1);
    end
    step(); s_stall_i = 0; settle();
    chk("t4_unstall", m0_stall_o, 0);
    step(); m0_stb_i = 0; settle();
    chk("t4_outst2", dut.outst_q, 2);

    // ---- abort with two outstanding, late acks must not reach m1 ----
    step(); m0_cyc_i = 0; m1_cyc_i = 1; settle();
    chk("t5_rel_cyc", s_cyc_o, 0);
    step(); settle();
    chk("t5_g1_outst", dut.outst_q, 0);
    chk("t5_g1_stall", m1_stall_o, 0);
    step(); s_ack_i = 1; settle();
    chk("t5_late_ack0", m1_ack_o, 0);
    step(); settle();
    chk("t5_late_ack1", m1_ack_o, 0);
    step(); s_ack_i = 0; m1_stb_i = 1; m1_addr_i = 32'hC0; settle();
    chk("t5_m1_stb", s_stb_o, 1);
    step(); m1_stb_i = 0; s_ack_i = 1; s_rdata_i = 32'h55; settle();
    chk("t5_m1_ack", m1_ack_o, 1);
    chk("t5_m1_rdata", m1_rdata_o, 32'h55);
    step(); s_ack_i = 0; settle();
    chk("t5_outst0", dut.outst_q, 0);

    // ---- reset in the middle of a burst ----
    step(); m1_stb_i = 1;
    step(); step();
    step(); m1_stb_i = 0; settle();
    chk("t6_outst3", dut.outst_q, 3);
    step(); reset_i = 1;
    step(); s_ack_i = 1; settle();
    chk("t6_cyc", s_cyc_o, 0);
    chk("t6_m0_stall", m0_stall_o, 1);
    chk("t6_m1_stall", m1_stall_o, 1);
    chk("t6_outst", dut.outst_q, 0);
    chk("t6_late_ack", m1_ack_o, 0);
    step(); reset_i = 0; m1_cyc_i = 0; s_ack_i = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
